// File: rtl/prio_arbiter.sv
// Registered N-way arbiter with a sticky valid/ready grant.
// Define ARB_RR_EN for round-robin selection; otherwise the highest set index wins.

module prio_arbiter #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 gnt_ready,
  output logic                 gnt_valid,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic [N-1:0]         gnt_onehot
);

  localparam int IDX_W = $clog2(N);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] ptr_nxt;
  logic [IDX_W-1:0] win;
  logic [IDX_W-1:0] idx_nxt;
  logic [N-1:0]     onehot_nxt;
  logic             valid_nxt;
  logic             any_req;
  logic             accept;
  logic             load;

  assign any_req = |req;
  assign accept  = (state == GRANT) && gnt_ready;

  // The back-to-back winner on an accept edge is chosen from the already-advanced pointer.
  assign ptr_nxt = accept ? ((gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + IDX_W'(1)) : ptr;

`ifdef ARB_RR_EN
  int j;

  always_comb begin
    win = '0;
    j   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr_nxt) + k;
      if (j >= N) begin
        j = j - N;
      end
      if (req[j[IDX_W-1:0]]) begin
        win = IDX_W'(j);
      end
    end
  end
`else
  always_comb begin
    win = '0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        win = IDX_W'(i);
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = GRANT;
      GRANT:   if (accept && !any_req) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load       = any_req && ((state == IDLE) || accept);
    valid_nxt  = (state_nxt == GRANT);
    idx_nxt    = load ? win : gnt_idx;
    onehot_nxt = valid_nxt ? (N'(1) << idx_nxt) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_valid  <= 1'b0;
      gnt_idx    <= '0;
      gnt_onehot <= '0;
      ptr        <= '0;
    end else begin
      gnt_valid  <= valid_nxt;
      gnt_idx    <= idx_nxt;
      gnt_onehot <= onehot_nxt;
      ptr        <= ptr_nxt;
    end
  end

endmodule

// File: tb/tb_prio_arbiter.sv
// Self-checking bench for prio_arbiter (N=4): directed scenarios then random traffic,
// compared against a rule-level model of the grant handshake.

module tb_prio_arbiter;

  localparam int N = 4;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic       gnt_ready;
  logic       gnt_valid;
  logic [1:0] gnt_idx;
  logic [3:0] gnt_onehot;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  // Model of what the consumer should see
  bit m_valid;
  int m_idx;
  int m_ptr;
  bit m_idx_known;

  prio_arbiter #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .gnt_ready  (gnt_ready),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx),
    .gnt_onehot (gnt_onehot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int model_winner(logic [3:0] r, int p);
`ifdef ARB_RR_EN
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
`else
    for (int i = N - 1; i >= 0; i--) begin
      if (r[i]) return i;
    end
`endif
    return 0;
  endfunction

  task automatic applyStimulus(input logic r_rst, input logic [3:0] r_req, input logic r_ready);
    @(negedge clk);
    rst       = r_rst;
    req       = r_req;
    gnt_ready = r_ready;
    @(posedge clk);
    if (r_rst) begin
      m_valid     = 1'b0;
      m_idx       = 0;
      m_ptr       = 0;
      m_idx_known = 1'b1;
    end else if (!m_valid) begin
      if (r_req != 4'b0000) begin
        m_valid     = 1'b1;
        m_idx       = model_winner(r_req, m_ptr);
        m_idx_known = 1'b1;
      end
    end else if (r_ready) begin
      m_ptr = (m_idx + 1) % N;
      if (r_req != 4'b0000) begin
        m_idx = model_winner(r_req, m_ptr);
      end else begin
        m_valid     = 1'b0;
        m_idx_known = 1'b0;
      end
    end
    #1;
  endtask

  task automatic checkOutput(input string tag);
    logic [3:0] exp_onehot;
    exp_onehot = m_valid ? (4'b0001 << m_idx) : 4'b0000;
    assert_cnt++;
    assert (gnt_valid === m_valid)
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s gnt_valid observed=%0b expected=%0b", tag, gnt_valid, m_valid);
    end
    assert_cnt++;
    assert (gnt_onehot === exp_onehot)
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s gnt_onehot observed=%b expected=%b", tag, gnt_onehot, exp_onehot);
    end
    if (m_idx_known) begin
      assert_cnt++;
      assert (gnt_idx === 2'(m_idx))
      else begin
        fail_cnt++;
        $error("[TB] FAIL %s gnt_idx observed=%0d expected=%0d", tag, gnt_idx, m_idx);
      end
    end
  endtask

  initial begin
    rst         = 1'b1;
    req         = 4'b0000;
    gnt_ready   = 1'b0;
    m_valid     = 1'b0;
    m_idx       = 0;
    m_ptr       = 0;
    m_idx_known = 1'b1;

    // Reset held two cycles with every request asserted
    applyStimulus(1'b1, 4'b1111, 1'b0);
    applyStimulus(1'b1, 4'b1111, 1'b0);
    checkOutput("reset");
    assert_cnt++;
    assert (gnt_valid === 1'b0 && gnt_idx === 2'd0 && gnt_onehot === 4'b0000)
    else begin
      fail_cnt++;
      $error("[TB] FAIL reset_literal observed=%0b/%0d/%b expected=0/0/0000", gnt_valid, gnt_idx, gnt_onehot);
    end

    // Basic selection with an immediate accept and a back-to-back winner
    applyStimulus(1'b0, 4'b1010, 1'b1);
    checkOutput("basic_first");
    applyStimulus(1'b0, 4'b0110, 1'b1);
    checkOutput("basic_second");
    assert_cnt++;
    assert (gnt_idx === 2'd2)
    else begin
      fail_cnt++;
      $error("[TB] FAIL basic_second_literal observed=%0d expected=2", gnt_idx);
    end

    // All requesters active, consumer always ready
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b0, 4'b1111, 1'b1);
      checkOutput("all_req");
    end

    // Drain to idle, then backpressure with a changing request
    applyStimulus(1'b0, 4'b0000, 1'b1);
    checkOutput("drain");
    applyStimulus(1'b0, 4'b0000, 1'b1);
    checkOutput("idle");
    applyStimulus(1'b0, 4'b0001, 1'b0);
    checkOutput("bp_grant");
    applyStimulus(1'b0, 4'b0100, 1'b0);
    checkOutput("bp_hold1");
    applyStimulus(1'b0, 4'b0100, 1'b0);
    checkOutput("bp_hold2");
    assert_cnt++;
    assert (gnt_idx === 2'd0 && gnt_valid === 1'b1)
    else begin
      fail_cnt++;
      $error("[TB] FAIL bp_hold_literal observed=%0d expected=0", gnt_idx);
    end
    applyStimulus(1'b0, 4'b0100, 1'b1);
    checkOutput("bp_accept");
    assert_cnt++;
    assert (gnt_idx === 2'd2)
    else begin
      fail_cnt++;
      $error("[TB] FAIL bp_accept_literal observed=%0d expected=2", gnt_idx);
    end

    // Pointer wrap past the top index, then return to idle on an empty accept
    applyStimulus(1'b0, 4'b0011, 1'b1);
    checkOutput("wrap");
    applyStimulus(1'b0, 4'b0000, 1'b1);
    checkOutput("wrap_idle");

    // Reset while a grant is outstanding
    applyStimulus(1'b0, 4'b0100, 1'b0);
    checkOutput("pre_reset_grant");
    applyStimulus(1'b1, 4'b0100, 1'b0);
    checkOutput("mid_reset");
    applyStimulus(1'b0, 4'b1111, 1'b0);
    checkOutput("post_reset_grant");
`ifdef ARB_RR_EN
    assert_cnt++;
    assert (gnt_idx === 2'd0)
    else begin
      fail_cnt++;
      $error("[TB] FAIL post_reset_literal observed=%0d expected=0", gnt_idx);
    end
`else
    assert_cnt++;
    assert (gnt_idx === 2'd3)
    else begin
      fail_cnt++;
      $error("[TB] FAIL post_reset_literal observed=%0d expected=3", gnt_idx);
    end
`endif

    // Random traffic with occasional resets
    for (int c = 0; c < 400; c++) begin
      applyStimulus($urandom_range(0, 39) == 0, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      checkOutput("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
